mem_port_arbiter: RTL



---
 rtl/mem_port_arbiter.sv | 111 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one split-handshake memory port between instruction fetch and data access,
// with an in-order owner FIFO for response routing. Define MEM_ARB_RR_EN for round-robin.
module mem_port_arbiter #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int PTR_W           = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);
  localparam logic SEL_INST = 1'b0;
  localparam logic SEL_DATA = 1'b1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(MAX_OUTSTANDING);

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [PTR_W:0]   count;
  logic             owner_q [MAX_OUTSTANDING];
  logic             lock_valid, lock_sel, last_grant;
  logic             sel, fire, pop, head, fifo_full, fifo_empty;

  always_comb begin
    sel = SEL_DATA;
    if (lock_valid) begin
      sel = lock_sel;
    end else if (inst_req & ~data_req) begin
      sel = SEL_INST;
    end else if (data_req & ~inst_req) begin
      sel = SEL_DATA;
    end else begin
`ifdef MEM_ARB_RR_EN
      sel = ~last_grant;
`else
      // Data side is older in program order; last_grant is tracked but has no say here.
      sel = SEL_DATA | (last_grant & 1'b0);
`endif
    end
  end

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);

  assign mem_req   = (inst_req | data_req) & ~fifo_full & ~reset;
  assign fire      = mem_req & mem_addr_ok;
  assign mem_wr    = (sel == SEL_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (sel == SEL_DATA) ? data_size  : inst_size;
  assign mem_addr  = (sel == SEL_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (sel == SEL_DATA) ? data_wdata : inst_wdata;

  assign inst_addr_ok = fire & (sel == SEL_INST);
  assign data_addr_ok = fire & (sel == SEL_DATA);

  // Responses with nothing outstanding (e.g. stale ones after reset) are dropped here.
  assign pop  = mem_data_ok & ~fifo_empty & ~reset;
  assign head = owner_q[rd_ptr];

  assign inst_data_ok = pop & (head == SEL_INST);
  assign data_data_ok = pop & (head == SEL_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      lock_valid <= 1'b0;
      lock_sel   <= SEL_INST;
      last_grant <= SEL_INST;
    end else begin
      if (fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W + 1)'(fire) - (PTR_W + 1)'(pop);
      if (fire) begin
        lock_valid <= 1'b0;
        last_grant <= sel;
      end else if (mem_req) begin
        // Pin the presented request until the bridge takes it.
        lock_valid <= 1'b1;
        lock_sel   <= sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (fire) owner_q[wr_ptr] <= sel;
  end

endmodule
